flash_responder: RTL

FLASH_RESPONDER -- requirements
Module: flash_responder

---
 rtl/flash_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/flash_responder.sv
// flash_responder: SPI flash read responder (opcode 0x03) backed by a
// 2^ADDR_BITS byte array that is written through a backdoor load port.
// The SPI bit clock is clk itself; every transfer bit is sampled on a rising edge.
//
// Ports
//   clk           system clock and SPI bit clock (rising edge)
//   resetn        synchronous active-low reset
//   csn_in        SPI chip select, active low
//   io0_in        MOSI from the initiator
//   io1_out       MISO to the initiator (registered)
//   io1_en        MISO output enable (registered)
//   load_en       backdoor byte-write strobe
//   load_addr     backdoor byte address
//   load_data     backdoor byte value
//   cmd_error_out one-cycle pulse after an unsupported opcode
module flash_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 csn_in,
  input  logic                 io0_in,
  output logic                 io1_out,
  output logic                 io1_en,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 cmd_error_out
);

  // The shifter only keeps what is actually consumed: opcode bits 7..1 at
  // edge 8, and address bits ADDR_BITS-1..1 at edge 32. Higher address bits
  // shift out the top and are dropped.
  localparam int SH_W = (ADDR_BITS - 1 > 7) ? ADDR_BITS - 1 : 7;

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [7:0]            dat_q, dat_d;
  logic                  armed_q, armed_d;
  logic                  miso_q, miso_d;
  logic                  en_q, en_d;
  logic                  err_q, err_d;

  logic [7:0]            mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [7:0]            rd_data;
  logic [7:0]            opcode;

  assign opcode  = {sh_q[6:0], io0_in};
  // At edge 32 the last address bit is still on io0_in, so the first fetch
  // address is formed combinationally from the shifter plus the live pin.
  assign rd_addr = (state_q == CMD) ? {sh_q[ADDR_BITS-2:0], io0_in} : addr_q;
  // Asynchronous read ahead of the registered write: a fetch and a load of
  // the same byte on one edge returns the old contents.
  assign rd_data = mem[rd_addr];

  // Byte array, never reset; loads are blocked while in reset.
  always_ff @(posedge clk) begin
    if (resetn && load_en) mem[load_addr] <= load_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      armed_q <= 1'b0;
      miso_q  <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      armed_q <= armed_d;
      miso_q  <= miso_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (csn_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        // A transaction may only begin once csn has been seen high since reset.
        IDLE:    if (armed_q) state_d = CMD;
        CMD: begin
          if (cnt_q == 5'd7 && opcode != 8'h03) state_d = IGNORE;
          else if (cnt_q == 5'd31)              state_d = DATA;
        end
        DATA:    state_d = DATA;
        IGNORE:  state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath / output logic
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    armed_d = armed_q | csn_in;
    miso_d  = 1'b0;
    en_d    = 1'b0;
    err_d   = 1'b0;
    if (csn_in) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            sh_d  = {{(SH_W-1){1'b0}}, io0_in};
            cnt_d = 5'd1;
          end
        end
        CMD: begin
          sh_d  = {sh_q[SH_W-2:0], io0_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7 && opcode != 8'h03) begin
            err_d = 1'b1;
          end else if (cnt_q == 5'd31) begin
            miso_d = rd_data[7];
            dat_d  = {rd_data[6:0], 1'b0};
            addr_d = rd_addr + ADDR_BITS'(1);
            en_d   = 1'b1;
            cnt_d  = 5'd1;
          end
        end
        DATA: begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 5'd1;
          // Low three counter bits give the bit position k mod 8.
          if (cnt_q[2:0] == 3'd0) begin
            miso_d = rd_data[7];
            dat_d  = {rd_data[6:0], 1'b0};
            addr_d = addr_q + ADDR_BITS'(1);
          end else begin
            miso_d = dat_q[7];
            dat_d  = {dat_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign io1_out       = miso_q;
  assign io1_en        = en_q;
  assign cmd_error_out = err_q;

endmodule
